// File: rtl/fill_line_ctrl.sv
// fill_line_ctrl: pill/bottle filling sequencer with a timed bottle-switch
// window, hopper starvation, conveyor stall and estop handling, and a bounded
// operator retry budget that ends in a latched FATAL state.
module fill_line_ctrl #(
  parameter int unsigned PILL_W     = 10,
  parameter int unsigned BOTL_W     = 7,
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned SWITCH_SEC = 2,
  parameter int unsigned HOPPER_SEC = 3,
  parameter int unsigned MAX_RETRY  = 3,
  localparam int unsigned RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic               clk_1khz,
  input  logic               rst_n,
  input  logic               load,
  input  logic [PILL_W-1:0]  tgt_pills_in,
  input  logic [BOTL_W-1:0]  tgt_bottles_in,
  input  logic               start,
  input  logic               clr,
  input  logic               resume,
  input  logic               estop,
  input  logic               pill_in,
  input  logic               conveyor_ok,
  output logic [2:0]         state,
  output logic [PILL_W-1:0]  now_pills,
  output logic [BOTL_W-1:0]  now_bottles,
  output logic [PILL_W-1:0]  tgt_pills,
  output logic [BOTL_W-1:0]  tgt_bottles,
  output logic [1:0]         err_code,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [1:0]         beep_mode
);

  // Encoding shared with the display layer.
  typedef enum logic [2:0] {
    S_SETTING   = 3'd0,
    S_RUNNING   = 3'd1,
    S_SWITCHING = 3'd2,
    S_DONE      = 3'd3,
    S_ERROR     = 3'd4,
    S_FATAL     = 3'd5
  } state_t;

  localparam int unsigned HOP_CYC = HOPPER_SEC * TICK_DIV;
  localparam int unsigned SW_CYC  = SWITCH_SEC * TICK_DIV;
  localparam int unsigned MAX_CYC = (HOP_CYC > SW_CYC) ? HOP_CYC : SW_CYC;
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0]   HOP_LOAD  = TMR_W'(HOP_CYC - 1);
  localparam logic [TMR_W-1:0]   SW_LOAD   = TMR_W'(SW_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_t             state_q, state_d;
  state_t             ret_q, ret_d;
  state_t             err_state;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               pill_q;
  logic               pill_edge;
  logic [PILL_W-1:0]  pills_d, tp_d;
  logic [BOTL_W-1:0]  bottles_d, tb_d, bottles_inc;
  logic [1:0]         err_d, beep_d;
  logic [RETRY_W-1:0] retry_d;

  assign state     = state_q;
  assign pill_edge = pill_in & ~pill_q;

  // Next-state and datapath updates; priority clr > estop > completion > pill > timer.
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    tmr_d     = tmr_q;
    pills_d   = now_pills;
    bottles_d = now_bottles;
    tp_d      = tgt_pills;
    tb_d      = tgt_bottles;
    err_d     = err_code;
    retry_d   = retry_cnt;
    // An exhausted retry budget turns any new error straight into FATAL.
    err_state   = (retry_cnt == RETRY_MAX) ? S_FATAL : S_ERROR;
    bottles_inc = (now_bottles == '1) ? now_bottles : now_bottles + BOTL_W'(1);

    if (clr) begin
      state_d   = S_SETTING;
      pills_d   = '0;
      bottles_d = '0;
      err_d     = '0;
      retry_d   = '0;
    end else if (estop && (state_q == S_RUNNING || state_q == S_SWITCHING ||
                           state_q == S_DONE)) begin
      state_d = err_state;
      err_d   = 2'd3;
      ret_d   = (state_q == S_SWITCHING) ? S_SWITCHING : S_RUNNING;
    end else begin
      case (state_q)
        S_SETTING: begin
          if (load) begin
            tp_d = tgt_pills_in;
            tb_d = tgt_bottles_in;
          end
          if (start && tgt_pills != '0 && tgt_bottles != '0) begin
            state_d   = S_RUNNING;
            pills_d   = '0;
            bottles_d = '0;
            tmr_d     = HOP_LOAD;
          end
        end
        S_RUNNING: begin
          if (now_pills == tgt_pills) begin
            bottles_d = bottles_inc;
            if (bottles_inc == tgt_bottles) begin
              state_d = S_DONE;
            end else begin
              state_d = S_SWITCHING;
              pills_d = '0;
              tmr_d   = SW_LOAD;
            end
          end else if (pill_edge) begin
            pills_d = now_pills + PILL_W'(1);
            tmr_d   = HOP_LOAD;
          end else if (tmr_q == '0) begin
            state_d = err_state;
            err_d   = 2'd1;
            ret_d   = S_RUNNING;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        S_SWITCHING: begin
          if (tmr_q == '0) begin
            if (conveyor_ok) begin
              state_d = S_RUNNING;
              tmr_d   = HOP_LOAD;
            end else begin
              state_d = err_state;
              err_d   = 2'd2;
              ret_d   = S_SWITCHING;
            end
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        S_DONE: begin
          if (start) begin
            state_d   = S_RUNNING;
            pills_d   = '0;
            bottles_d = '0;
            tmr_d     = HOP_LOAD;
          end
        end
        S_ERROR: begin
          if (resume && !estop) begin
            retry_d = retry_cnt + RETRY_W'(1);
            err_d   = '0;
            state_d = ret_q;
            tmr_d   = (ret_q == S_SWITCHING) ? SW_LOAD : HOP_LOAD;
          end
        end
        S_FATAL: begin
        end
        default: state_d = S_SETTING;
      endcase
    end

    case (state_q)
      S_DONE:  beep_d = 2'd1;
      S_ERROR: beep_d = 2'd2;
      S_FATAL: beep_d = 2'd3;
      default: beep_d = 2'd0;
    endcase
  end

  // State, counters, targets and beeper register.
  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SETTING;
      ret_q       <= S_RUNNING;
      tmr_q       <= '0;
      pill_q      <= 1'b0;
      now_pills   <= '0;
      now_bottles <= '0;
      tgt_pills   <= '0;
      tgt_bottles <= '0;
      err_code    <= '0;
      retry_cnt   <= '0;
      beep_mode   <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      tmr_q       <= tmr_d;
      pill_q      <= pill_in;
      now_pills   <= pills_d;
      now_bottles <= bottles_d;
      tgt_pills   <= tp_d;
      tgt_bottles <= tb_d;
      err_code    <= err_d;
      retry_cnt   <= retry_d;
      beep_mode   <= beep_d;
    end
  end

endmodule

// File: tb/tb_fill_line_ctrl.sv
// Directed scenario bench for fill_line_ctrl with randomized targets and pill
// gaps; expectations come from a transaction-level model of the batch.
module tb_fill_line_ctrl;

  localparam int unsigned PILL_W     = 10;
  localparam int unsigned BOTL_W     = 7;
  localparam int unsigned TICK_DIV   = 10;
  localparam int unsigned SWITCH_SEC = 2;
  localparam int unsigned HOPPER_SEC = 3;
  localparam int unsigned MAX_RETRY  = 1;
  localparam int unsigned RETRY_W    = $clog2(MAX_RETRY + 1);
  localparam int          HOP        = HOPPER_SEC * TICK_DIV;
  localparam int          SW         = SWITCH_SEC * TICK_DIV;

  localparam int ST_SET = 0, ST_RUN = 1, ST_SW = 2, ST_DONE = 3, ST_ERR = 4, ST_FATAL = 5;

  logic               clk_1khz = 1'b0;
  logic               rst_n = 1'b0;
  logic               load = 1'b0, start = 1'b0, clr = 1'b0, resume = 1'b0;
  logic               estop = 1'b0, pill_in = 1'b0, conveyor_ok = 1'b1;
  logic [PILL_W-1:0]  tgt_pills_in = '0;
  logic [BOTL_W-1:0]  tgt_bottles_in = '0;
  logic [2:0]         state;
  logic [PILL_W-1:0]  now_pills, tgt_pills;
  logic [BOTL_W-1:0]  now_bottles, tgt_bottles;
  logic [1:0]         err_code, beep_mode;
  logic [RETRY_W-1:0] retry_cnt;

  int vectors = 0;
  int miscompares = 0;
  int m_state, m_pills, m_bottles, m_err, m_retry, m_tp, m_tb;

  fill_line_ctrl #(
    .PILL_W(PILL_W), .BOTL_W(BOTL_W), .TICK_DIV(TICK_DIV),
    .SWITCH_SEC(SWITCH_SEC), .HOPPER_SEC(HOPPER_SEC), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk_1khz(clk_1khz), .rst_n(rst_n), .load(load),
    .tgt_pills_in(tgt_pills_in), .tgt_bottles_in(tgt_bottles_in),
    .start(start), .clr(clr), .resume(resume), .estop(estop),
    .pill_in(pill_in), .conveyor_ok(conveyor_ok), .state(state),
    .now_pills(now_pills), .now_bottles(now_bottles),
    .tgt_pills(tgt_pills), .tgt_bottles(tgt_bottles),
    .err_code(err_code), .retry_cnt(retry_cnt), .beep_mode(beep_mode)
  );

  always #5 clk_1khz = ~clk_1khz;

  task automatic tick();
    @(posedge clk_1khz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},   32'(state),       m_state);
    chk({tag, ".pills"},   32'(now_pills),   m_pills);
    chk({tag, ".bottles"}, 32'(now_bottles), m_bottles);
    chk({tag, ".err"},     32'(err_code),    m_err);
    chk({tag, ".retry"},   32'(retry_cnt),   m_retry);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_targets(input int tp, input int tb);
    tgt_pills_in   = PILL_W'(tp);
    tgt_bottles_in = BOTL_W'(tb);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic model_clear();
    m_pills = 0;
    m_bottles = 0;
    m_err = 0;
    m_retry = 0;
  endtask

  // Time limit for the whole run.
  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    m_state = ST_SET; model_clear(); m_tp = 0; m_tb = 0;
    tick(); tick();
    check_all("reset");
    chk("reset.tp", 32'(tgt_pills), 0);
    chk("reset.beep", 32'(beep_mode), 0);
    rst_n = 1'b1;
    tick();

    // Nominal batch with random targets and random pill gaps
    m_tp = int'($urandom_range(6, 2));
    m_tb = int'($urandom_range(4, 2));
    load_targets(m_tp, m_tb);
    chk("load.tp", 32'(tgt_pills), m_tp);
    chk("load.tb", 32'(tgt_bottles), m_tb);
    pulse_start();
    m_state = ST_RUN;
    check_all("start");
    tgt_pills_in = PILL_W'(m_tp + 3);
    load = 1'b1; tick(); load = 1'b0;
    chk("load_ignored", 32'(tgt_pills), m_tp);
    for (int b = 0; b < m_tb; b++) begin
      for (int p = 0; p < m_tp; p++) begin
        repeat ($urandom_range(6, 0)) tick();
        pill_in = 1'b1; tick(); pill_in = 1'b0;
        m_pills++;
        chk("pill_count", 32'(now_pills), m_pills);
        tick();
      end
      m_bottles++;
      if (m_bottles == m_tb) begin
        m_state = ST_DONE;
      end else begin
        m_state = ST_SW;
        m_pills = 0;
      end
      check_all("bottle_done");
      if (m_state == ST_SW) begin
        pill_in = 1'b1; tick(); pill_in = 1'b0; tick();
        repeat (SW - 3) tick();
        check_all("switch_hold");
        tick();
        m_state = ST_RUN;
        check_all("switch_exp");
      end
    end
    chk("beep_lag_done", 32'(beep_mode), 0);
    tick();
    chk("beep_done", 32'(beep_mode), 1);

    // Re-run from DONE, then hopper starvation and resume
    pulse_start();
    m_state = ST_RUN; m_pills = 0; m_bottles = 0;
    check_all("rerun");
    pill_in = 1'b1; tick(); pill_in = 1'b0; m_pills = 1; tick();
    repeat (HOP - 2) tick();
    check_all("hop_hold");
    tick();
    m_state = ST_ERR; m_err = 1;
    check_all("starve");
    tick();
    chk("beep_error", 32'(beep_mode), 2);
    resume = 1'b1; tick(); resume = 1'b0;
    m_state = ST_RUN; m_err = 0; m_retry = 1;
    check_all("resume_starve");
    repeat (HOP - 1) tick();
    pill_in = 1'b1; tick(); pill_in = 1'b0;
    m_pills = 2;
    check_all("pill_at_expiry");
    tick();
    estop = 1'b1; clr = 1'b1; tick(); estop = 1'b0; clr = 1'b0;
    m_state = ST_SET; model_clear();
    check_all("clr_estop");
    chk("clr_keeps_tp", 32'(tgt_pills), m_tp);
    chk("clr_keeps_tb", 32'(tgt_bottles), m_tb);

    // Conveyor stall at the end of the switch window
    pulse_start();
    m_state = ST_RUN;
    for (int p = 0; p < m_tp; p++) begin
      pill_in = 1'b1; tick(); pill_in = 1'b0; tick();
    end
    m_state = ST_SW; m_bottles = 1; m_pills = 0;
    check_all("stall_sw");
    conveyor_ok = 1'b0;
    repeat (SW - 1) tick();
    check_all("stall_hold");
    tick();
    m_state = ST_ERR; m_err = 2;
    check_all("stall");
    conveyor_ok = 1'b1;
    resume = 1'b1; tick(); resume = 1'b0;
    m_state = ST_SW; m_err = 0; m_retry = 1;
    check_all("stall_resume");
    repeat (SW - 1) tick();
    check_all("fresh_window");
    tick();
    m_state = ST_RUN;
    check_all("stall_recover");
    clr = 1'b1; tick(); clr = 1'b0;
    m_state = ST_SET; model_clear();
    check_all("clr_after_stall");

    // Estop beats completion, pill edge on completion cycle, retry budget
    pulse_start();
    m_state = ST_RUN;
    for (int p = 0; p < m_tp - 1; p++) begin
      pill_in = 1'b1; tick(); pill_in = 1'b0; tick();
      m_pills++;
    end
    pill_in = 1'b1; tick(); pill_in = 1'b0;
    m_pills = m_tp;
    check_all("last_pill");
    estop = 1'b1; tick();
    m_state = ST_ERR; m_err = 3;
    check_all("estop_over_completion");
    resume = 1'b1; tick();
    check_all("resume_blocked");
    estop = 1'b0; tick(); resume = 1'b0;
    m_state = ST_RUN; m_err = 0; m_retry = 1;
    check_all("estop_resume");
    pill_in = 1'b1; tick(); pill_in = 1'b0;
    m_state = ST_SW; m_pills = 0; m_bottles = 1;
    check_all("pill_on_completion");
    estop = 1'b1; tick();
    m_state = ST_FATAL; m_err = 3;
    check_all("fatal");
    chk("beep_lag_fatal", 32'(beep_mode), 0);
    tick();
    chk("beep_fatal", 32'(beep_mode), 3);
    estop = 1'b0; resume = 1'b1; tick(); resume = 1'b0;
    check_all("fatal_resume_ignored");
    clr = 1'b1; tick(); clr = 1'b0;
    m_state = ST_SET; model_clear();
    check_all("fatal_clr");
    tick();
    chk("beep_silent", 32'(beep_mode), 0);

    // Invalid starts with a zero target
    m_tp = 0; m_tb = int'($urandom_range(4, 1));
    load_targets(m_tp, m_tb);
    pulse_start();
    check_all("zero_pills_start");
    m_tp = int'($urandom_range(6, 1)); m_tb = 0;
    load_targets(m_tp, m_tb);
    pulse_start();
    check_all("zero_bottles_start");
    chk("zero_bottles_tp", 32'(tgt_pills), m_tp);

    // Asynchronous reset mid-RUNNING
    m_tp = int'($urandom_range(6, 2)); m_tb = int'($urandom_range(4, 2));
    load_targets(m_tp, m_tb);
    pulse_start();
    m_state = ST_RUN;
    pill_in = 1'b1; tick(); pill_in = 1'b0; tick();
    m_pills = 1;
    check_all("pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    m_state = ST_SET; model_clear();
    check_all("async_reset");
    chk("async_reset.tp", 32'(tgt_pills), 0);
    chk("async_reset.tb", 32'(tgt_bottles), 0);
    chk("async_reset.beep", 32'(beep_mode), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_all("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
